// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
// Holds the controller state encoding.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fa_bit_cell.sv
// One-bit full adder built from two half-adder stages and an OR for carry.
module fa_bit_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1, c1, c2;

  assign s1 = x ^ y;
  assign c1 = x & y;
  assign s  = s1 ^ ci;
  assign c2 = s1 & ci;
  assign co = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full-adder cell, one bit per clock, LSB first.
// Result, carry-out and signed overflow are published together with a one-cycle done pulse.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] opa, opb, res;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cell_s, cell_co;

  fa_bit_cell u_cell (
    .x  (opa[0]),
    .y  (opb[0]),
    .ci (carry),
    .s  (cell_s),
    .co (cell_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= a;
            // Subtract as a + ~b + 1; cin is ignored.
            opb   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          res   <= {cell_s, res[WIDTH-1:1]};
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= cell_co;
          if (cnt == CntLast) begin
            // carry here is the carry into the MSB.
            sum   <= {cell_s, res[WIDTH-1:1]};
            cout  <= cell_co;
            ovf   <= carry ^ cell_co;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8) with hand-computed expectations.
module tb_serial_add_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, sub, cin;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, cout, ovf;
  logic [WIDTH-1:0] sum;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] last_sum;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  // Full operation from an idle start pulse; checks timing and result.
  task automatic run_op(input string tag, input logic s, input logic [WIDTH-1:0] va,
                        input logic [WIDTH-1:0] vb, input logic c,
                        input logic [WIDTH-1:0] e_sum, input logic e_cout,
                        input logic e_ovf);
    sub = s; a = va; b = vb; cin = c; start = 1'b1;
    edge_sample();  // E0
    start = 1'b0;
    check({tag, " busy@E0"}, 32'(busy), 32'd1);
    for (int i = 1; i < WIDTH; i++) begin
      edge_sample();
      check({tag, " done@run"}, 32'(done), 32'd0);
      check({tag, " sum held"}, 32'(sum), 32'(last_sum));
    end
    edge_sample();  // E_WIDTH
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " sum"}, 32'(sum), 32'(e_sum));
    check({tag, " cout"}, 32'(cout), 32'(e_cout));
    check({tag, " ovf"}, 32'(ovf), 32'(e_ovf));
    edge_sample();  // E_WIDTH+1
    check({tag, " done off"}, 32'(done), 32'd0);
    check({tag, " busy off"}, 32'(busy), 32'd0);
    last_sum = e_sum;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    last_sum = '0;
    #22;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst sum", 32'(sum), 32'd0);
    check("rst cout", 32'(cout), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    edge_sample();

    run_op("add ff+01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("sub 05-07", 1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
    run_op("sub 80-01", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
    run_op("add 7f+01", 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("add 12+34+1", 1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

    // Restart and operand changes while busy must be ignored.
    sub = 1'b0; a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    edge_sample();  // E0
    start = 1'b0;
    for (int i = 1; i < WIDTH; i++) begin
      if (i == 2) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b1;
      end
      if (i == 3) start = 1'b0;
      edge_sample();
      check("ignore done@run", 32'(done), 32'd0);
      check("ignore busy@run", 32'(busy), 32'd1);
    end
    edge_sample();  // E8
    check("ignore done", 32'(done), 32'd1);
    check("ignore sum", 32'(sum), 32'h30);
    check("ignore cout", 32'(cout), 32'd0);
    edge_sample();
    check("ignore done once", 32'(done), 32'd0);
    last_sum = 8'h30;

    // start held high: accepts at E0, E10, E20.
    sub = 1'b0; a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      edge_sample();
      check("held done", 32'(done), 32'((i % 10) == 8));
      check("held busy", 32'(busy), 32'((i % 10) != 9));
      check("held sum", 32'(sum), (i >= 8) ? 32'h07 : 32'(last_sum));
    end
    start = 1'b0;
    edge_sample();
    check("held idle", 32'(busy), 32'd0);
    last_sum = 8'h07;

    // Asynchronous reset mid-operation.
    sub = 1'b0; a = 8'h21; b = 8'h11; cin = 1'b0; start = 1'b1;
    edge_sample();  // E0
    start = 1'b0;
    repeat (4) edge_sample();  // E4
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort sum", 32'(sum), 32'd0);
    check("abort cout", 32'(cout), 32'd0);
    check("abort ovf", 32'(ovf), 32'd0);
    edge_sample();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      edge_sample();
      check("abort no done", 32'(done), 32'd0);
    end
    last_sum = '0;
    run_op("after reset", 1'b0, 8'h21, 8'h11, 1'b0, 8'h32, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
